// File: rtl/fft8_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft8_frame_ctrl
// Summary  : Frame sequencer for the butterfly8 datapath. It loads 8 samples,
//            holds them for a settle time, then unloads 8 bins. The optional
//            macro FFT8_OVERLAP_EN loads the next frame while the current one
//            is being unloaded.
// Revision : 1.0 - initial release
// ============================================================================
module fft8_frame_ctrl #(
  parameter int DW            = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [2:0]      out_idx,
  output logic            out_last,
  output logic [8*DW-1:0] dp_a_re,
  output logic [8*DW-1:0] dp_a_im,
  input  logic [8*DW-1:0] dp_c_re,
  input  logic [8*DW-1:0] dp_c_im,
  output logic            busy,
  output logic [15:0]     frame_cnt
);

  localparam logic [1:0] c_ST_LOAD   = 2'd0;
  localparam logic [1:0] c_ST_SETTLE = 2'd1;
  localparam logic [1:0] c_ST_UNLOAD = 2'd2;
  localparam logic [3:0] c_SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [1:0]    r_state;
  logic          r_run;
  logic [2:0]    r_wr_idx;
  logic [2:0]    r_rd_idx;
  logic [3:0]    r_settle_cnt;
  logic [15:0]   r_frame_cnt;
  logic [DW-1:0] r_ibuf_re [8];
  logic [DW-1:0] r_ibuf_im [8];
  logic [DW-1:0] r_obuf_re [8];
  logic [DW-1:0] r_obuf_im [8];

  logic w_in_fire;
  logic w_out_fire;
  logic w_in_last;
  logic w_out_done;
  logic w_settle_done;
  logic w_enter_settle;

  assign w_in_fire     = in_valid && in_ready;
  assign w_out_fire    = out_valid && out_ready;
  assign w_in_last     = w_in_fire && (r_wr_idx == 3'd7);
  assign w_out_done    = w_out_fire && (r_rd_idx == 3'd7);
  assign w_settle_done = (r_state == c_ST_SETTLE) && (r_settle_cnt == 4'd0);

`ifdef FFT8_OVERLAP_EN
  logic r_ibuf_full;

  assign in_ready       = r_run && !r_ibuf_full &&
                          ((r_state == c_ST_LOAD) || (r_state == c_ST_UNLOAD));
  // A frame completed during unload starts settling as soon as the bins drain.
  assign w_enter_settle = ((r_state == c_ST_LOAD) && w_in_last) ||
                          (w_out_done && (r_ibuf_full || w_in_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ibuf_full <= 1'b0;
    end else if (w_enter_settle) begin
      r_ibuf_full <= 1'b0;
    end else if (w_in_last) begin
      r_ibuf_full <= 1'b1;
    end
  end
`else
  assign in_ready       = r_run && (r_state == c_ST_LOAD);
  assign w_enter_settle = (r_state == c_ST_LOAD) && w_in_last;
`endif

  // in_ready stays low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_LOAD;
      r_settle_cnt <= 4'd0;
      r_rd_idx     <= 3'd0;
      r_frame_cnt  <= 16'd0;
    end else begin
      if (w_enter_settle) begin
        r_state      <= c_ST_SETTLE;
        r_settle_cnt <= c_SETTLE_INIT;
      end else begin
        case (r_state)
          c_ST_SETTLE: begin
            // Counting down to zero holds the frame for the entry cycle plus SETTLE_CYCLES.
            if (r_settle_cnt == 4'd0) begin
              r_state  <= c_ST_UNLOAD;
              r_rd_idx <= 3'd0;
            end else begin
              r_settle_cnt <= r_settle_cnt - 4'd1;
            end
          end
          c_ST_UNLOAD: begin
            if (w_out_done) begin
              r_state <= c_ST_LOAD;
            end
          end
          default: r_state <= c_ST_LOAD;
        endcase
      end
      if (w_out_fire) begin
        r_rd_idx <= r_rd_idx + 3'd1;
      end
      if (w_out_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        r_ibuf_re[k] <= '0;
        r_ibuf_im[k] <= '0;
      end
    end else if (w_in_fire) begin
      r_ibuf_re[r_wr_idx] <= in_re;
      r_ibuf_im[r_wr_idx] <= in_im;
      r_wr_idx            <= r_wr_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        r_obuf_re[k] <= '0;
        r_obuf_im[k] <= '0;
      end
    end else if (w_settle_done) begin
      for (int k = 0; k < 8; k++) begin
        r_obuf_re[k] <= dp_c_re[k*DW +: DW];
        r_obuf_im[k] <= dp_c_im[k*DW +: DW];
      end
    end
  end

  generate
    for (genvar k = 0; k < 8; k++) begin : g_pack
      assign dp_a_re[k*DW +: DW] = r_ibuf_re[k];
      assign dp_a_im[k*DW +: DW] = r_ibuf_im[k];
    end
  endgenerate

  assign out_valid = (r_state == c_ST_UNLOAD);
  assign out_re    = r_obuf_re[r_rd_idx];
  assign out_im    = r_obuf_im[r_rd_idx];
  assign out_idx   = r_rd_idx;
  assign out_last  = out_valid && (r_rd_idx == 3'd7);
  assign busy      = (r_state != c_ST_LOAD) || (r_wr_idx != 3'd0);
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
